// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
// Optional feature macro: MEM_ARB_RR_EN (round-robin instead of fixed priority).
package mem_port_arbiter_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned MEM_PORTS = 2;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StDone
  } mem_arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, grouped as one bundle.
// master: the requesters plus the memory model; slave: the arbiter itself.
interface mem_port_arbiter_if #(
  parameter int unsigned N_PORTS = mem_port_arbiter_pkg::MEM_PORTS,
  parameter int unsigned XLEN    = mem_port_arbiter_pkg::XLEN
);
  localparam int unsigned BE_W = XLEN / 8;

  logic [N_PORTS-1:0]      p_req;
  logic [N_PORTS-1:0]      p_we;
  logic [N_PORTS*XLEN-1:0] p_addr;
  logic [N_PORTS*BE_W-1:0] p_byteen;
  logic [N_PORTS*XLEN-1:0] p_wdata;
  logic [N_PORTS-1:0]      p_gnt;
  logic [N_PORTS-1:0]      p_ack;
  logic [XLEN-1:0]         p_rdata;
  logic                    p_err;
  logic                    mem_req;
  logic                    mem_we;
  logic [XLEN-1:0]         mem_addr;
  logic [BE_W-1:0]         mem_byteen;
  logic [XLEN-1:0]         mem_wdata;
  logic [XLEN-1:0]         mem_rdata;
  logic                    mem_err;

  modport master (
    output p_req, p_we, p_addr, p_byteen, p_wdata, mem_rdata, mem_err,
    input  p_gnt, p_ack, p_rdata, p_err, mem_req, mem_we, mem_addr, mem_byteen, mem_wdata
  );

  modport slave (
    input  p_req, p_we, p_addr, p_byteen, p_wdata, mem_rdata, mem_err,
    output p_gnt, p_ack, p_rdata, p_err, mem_req, mem_we, mem_addr, mem_byteen, mem_wdata
  );

endinterface

// File: rtl/mem_arb_picker.sv
// Combinational winner selection. MEM_ARB_RR_EN: search from ptr upwards with wrap;
// otherwise lowest requesting index wins and ptr is ignored.
module mem_arb_picker #(
  parameter  int unsigned N_PORTS = 2,
  localparam int unsigned IDX_W   = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [N_PORTS-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

`ifdef MEM_ARB_RR_EN
  // First requester found walking from ptr, wrapping at N_PORTS.
  always_comb begin
    logic [IDX_W-1:0] cand;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      cand = IDX_W'((32'(ptr) + k) % N_PORTS);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Lowest requesting index wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      if (!valid && req[IDX_W'(k)]) begin
        valid           = 1'b1;
        idx             = IDX_W'(k);
        gnt[IDX_W'(k)]  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between N_PORTS requesters using a fixed
// IDLE -> ADDR -> DATA -> DONE sequence (4 cycles per transfer, no overlap).
// Optional feature macro: MEM_ARB_RR_EN selects round-robin arbitration.
module mem_port_arbiter #(
  parameter  int unsigned N_PORTS = mem_port_arbiter_pkg::MEM_PORTS,
  parameter  int unsigned XLEN    = mem_port_arbiter_pkg::XLEN,
  localparam int unsigned BE_W    = XLEN / 8,
  localparam int unsigned IDX_W   = $clog2(N_PORTS)
) (
  input  logic            clk,
  input  logic            rst,
  mem_port_arbiter_if.slave bus
);
  import mem_port_arbiter_pkg::*;

  mem_arb_state_t     state_q, state_d;
  logic               we_q;
  logic [XLEN-1:0]    addr_q, wdata_q, rdata_q;
  logic [BE_W-1:0]    byteen_q;
  logic               err_q;
  logic [N_PORTS-1:0] win_oh_q;

  logic [N_PORTS-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [IDX_W-1:0]   ptr;

  logic [N_PORTS-1:0] p_gnt, p_ack;
  logic [XLEN-1:0]    p_rdata, mem_addr, mem_wdata;
  logic               p_err, mem_req, mem_we;
  logic [BE_W-1:0]    mem_byteen;

  mem_arb_picker #(
    .N_PORTS(N_PORTS)
  ) u_picker (
    .req  (bus.p_req),
    .ptr  (ptr),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .valid(pick_valid)
  );

`ifdef MEM_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q;

  // Next search start = last winner + 1 (mod N_PORTS), updated when a grant is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (state_q == StIdle && pick_valid) begin
      ptr_q <= (pick_idx == IDX_W'(N_PORTS - 1)) ? '0 : pick_idx + 1'b1;
    end
  end
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state: fixed sequence once a request is taken.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pick_valid) state_d = StAddr;
      StAddr:  state_d = StData;
      StData:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Capture the winner's request on grant and the memory response at end of DATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      byteen_q <= '0;
      win_oh_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == StIdle && pick_valid) begin
        we_q     <= bus.p_we[pick_idx];
        addr_q   <= bus.p_addr[pick_idx*XLEN +: XLEN];
        wdata_q  <= bus.p_wdata[pick_idx*XLEN +: XLEN];
        byteen_q <= bus.p_byteen[pick_idx*BE_W +: BE_W];
        win_oh_q <= pick_gnt;
      end
      if (state_q == StData) begin
        rdata_q <= we_q ? '0 : bus.mem_rdata;
        err_q   <= bus.mem_err;
      end
    end
  end

  // Outputs decoded purely from state and latched request.
  always_comb begin
    p_gnt      = '0;
    p_ack      = '0;
    p_rdata    = '0;
    p_err      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_byteen = '0;
    mem_wdata  = '0;
    unique case (state_q)
      StAddr, StData: begin
        p_gnt     = win_oh_q;
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = {addr_q[XLEN-1:2], 2'b00};
        mem_wdata = wdata_q;
        // Byte lanes only qualify the DATA phase.
        if (state_q == StData) mem_byteen = byteen_q;
      end
      StDone: begin
        p_gnt   = win_oh_q;
        p_ack   = win_oh_q;
        p_rdata = rdata_q;
        p_err   = err_q;
      end
      default: ;
    endcase
  end

  assign bus.p_gnt      = p_gnt;
  assign bus.p_ack      = p_ack;
  assign bus.p_rdata    = p_rdata;
  assign bus.p_err      = p_err;
  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_byteen = mem_byteen;
  assign bus.mem_wdata  = mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int unsigned NP = 2;
  localparam int unsigned XL = 32;
  localparam int unsigned BW = XL / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.N_PORTS(NP), .XLEN(XL)) bus ();

  mem_port_arbiter #(
    .N_PORTS(NP),
    .XLEN   (XL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned port;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] mrd;
    logic        merr;
    logic [31:0] exp_maddr;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int unsigned p, input logic we, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
    bus.p_we[p]             = we;
    bus.p_addr[p*XL +: XL]  = a;
    bus.p_byteen[p*BW +: BW] = be;
    bus.p_wdata[p*XL +: XL] = wd;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.p_req     = '0;
    bus.p_we      = '0;
    bus.p_addr    = '0;
    bus.p_byteen  = '0;
    bus.p_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_err   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [NP-1:0] onehot(input int unsigned p);
    logic [NP-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // One isolated transfer, checked phase by phase; fields are scrambled after grant.
  task automatic run_vec(input vec_t v, input string tag);
    logic [NP-1:0] oh;
    oh = onehot(v.port);
    set_port(v.port, v.we, v.addr, v.be, v.wdata);
    bus.p_req[v.port] = 1'b1;
    tick();
    set_port(v.port, ~v.we, 32'hDEAD_0001, ~v.be, ~v.wdata);
    chk({tag, ".addr.mem_req"}, 64'(bus.mem_req), 64'(1'b1));
    chk({tag, ".addr.mem_we"}, 64'(bus.mem_we), 64'(v.we));
    chk({tag, ".addr.mem_addr"}, 64'(bus.mem_addr), 64'(v.exp_maddr));
    chk({tag, ".addr.byteen"}, 64'(bus.mem_byteen), 64'(0));
    chk({tag, ".addr.wdata"}, 64'(bus.mem_wdata), 64'(v.wdata));
    chk({tag, ".addr.gnt"}, 64'(bus.p_gnt), 64'(oh));
    chk({tag, ".addr.ack"}, 64'(bus.p_ack), 64'(0));
    tick();
    bus.mem_rdata = v.mrd;
    bus.mem_err   = v.merr;
    chk({tag, ".data.byteen"}, 64'(bus.mem_byteen), 64'(v.be));
    chk({tag, ".data.mem_addr"}, 64'(bus.mem_addr), 64'(v.exp_maddr));
    chk({tag, ".data.wdata"}, 64'(bus.mem_wdata), 64'(v.wdata));
    chk({tag, ".data.gnt"}, 64'(bus.p_gnt), 64'(oh));
    tick();
    bus.mem_rdata = '0;
    bus.mem_err   = 1'b0;
    chk({tag, ".done.ack"}, 64'(bus.p_ack), 64'(oh));
    chk({tag, ".done.gnt"}, 64'(bus.p_gnt), 64'(oh));
    chk({tag, ".done.rdata"}, 64'(bus.p_rdata), 64'(v.exp_rd));
    chk({tag, ".done.err"}, 64'(bus.p_err), 64'(v.exp_err));
    chk({tag, ".done.mem_req"}, 64'(bus.mem_req), 64'(0));
    bus.p_req[v.port] = 1'b0;
    tick();
    chk({tag, ".idle.gnt"}, 64'(bus.p_gnt), 64'(0));
    chk({tag, ".idle.ack"}, 64'(bus.p_ack), 64'(0));
    chk({tag, ".idle.mem_req"}, 64'(bus.mem_req), 64'(0));
    chk({tag, ".idle.rdata"}, 64'(bus.p_rdata), 64'(0));
  endtask

  // Reference model state for random traffic.
  logic [NP-1:0] pend;
  logic          m_we[NP];
  logic [31:0]   m_addr[NP];
  logic [3:0]    m_be[NP];
  logic [31:0]   m_wd[NP];
`ifdef MEM_ARB_RR_EN
  int unsigned   rr_next;
`endif

  function automatic int unsigned model_pick(input logic [NP-1:0] req);
`ifdef MEM_ARB_RR_EN
    for (int unsigned k = 0; k < NP; k++) begin
      int unsigned c = (rr_next + k) % NP;
      if (req[c]) return c;
    end
`else
    for (int unsigned k = 0; k < NP; k++) if (req[k]) return k;
`endif
    return 0;
  endfunction

  initial begin
    vecs[0] = '{port: 0, we: 1'b0, addr: 32'h0000_0103, be: 4'b0010, wdata: 32'h0,
                mrd: 32'hA1B2_C3D4, merr: 1'b0, exp_maddr: 32'h0000_0100,
                exp_rd: 32'hA1B2_C3D4, exp_err: 1'b0};
    vecs[1] = '{port: 1, we: 1'b1, addr: 32'h0000_0200, be: 4'b0011, wdata: 32'h0000_BEEF,
                mrd: 32'h55AA_55AA, merr: 1'b0, exp_maddr: 32'h0000_0200,
                exp_rd: 32'h0, exp_err: 1'b0};
    vecs[2] = '{port: 0, we: 1'b0, addr: 32'h0000_0047, be: 4'b1111, wdata: 32'h0,
                mrd: 32'hCAFE_F00D, merr: 1'b1, exp_maddr: 32'h0000_0044,
                exp_rd: 32'hCAFE_F00D, exp_err: 1'b1};
    vecs[3] = '{port: 1, we: 1'b0, addr: 32'hFFFF_FFFE, be: 4'b0000, wdata: 32'h0,
                mrd: 32'h1234_5678, merr: 1'b0, exp_maddr: 32'hFFFF_FFFC,
                exp_rd: 32'h1234_5678, exp_err: 1'b0};
    vecs[4] = '{port: 0, we: 1'b1, addr: 32'h0000_0008, be: 4'b1000, wdata: 32'h1122_3344,
                mrd: 32'hFFFF_FFFF, merr: 1'b1, exp_maddr: 32'h0000_0008,
                exp_rd: 32'h0, exp_err: 1'b1};

    do_reset();
    chk("reset.mem_req", 64'(bus.mem_req), 64'(0));
    chk("reset.gnt", 64'(bus.p_gnt), 64'(0));
    chk("reset.ack", 64'(bus.p_ack), 64'(0));
    chk("reset.mem_addr", 64'(bus.mem_addr), 64'(0));
    chk("reset.rdata", 64'(bus.p_rdata), 64'(0));

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Contention: both ports hold requests for four transfers.
    begin
      int unsigned order[$];
      int unsigned exp_order[4];
      int cyc;
`ifdef MEM_ARB_RR_EN
      exp_order = '{0, 1, 0, 1};
`else
      exp_order = '{0, 0, 0, 0};
`endif
      do_reset();
      set_port(0, 1'b0, 32'h10, 4'hF, 32'h0);
      set_port(1, 1'b0, 32'h20, 4'hF, 32'h0);
      bus.p_req = 2'b11;
      cyc = 0;
      while (order.size() < 4 && cyc < 40) begin
        tick();
        cyc++;
        if (bus.p_ack == 2'b01) order.push_back(0);
        else if (bus.p_ack == 2'b10) order.push_back(1);
        else if (bus.p_ack != 2'b00) order.push_back(99);
      end
      chk("cont.count", 64'(order.size()), 64'(4));
      chk("cont.cycles", 64'(cyc), 64'(15));
      for (int i = 0; i < 4 && i < order.size(); i++)
        chk($sformatf("cont.order%0d", i), 64'(order[i]), 64'(exp_order[i]));
      bus.p_req = '0;
      tick();
    end

    // Reset during DATA drops the transfer without ack.
    begin
      logic saw_ack;
      do_reset();
      set_port(1, 1'b0, 32'h300, 4'hF, 32'h0);
      bus.p_req[1] = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("rst.mem_req", 64'(bus.mem_req), 64'(0));
      chk("rst.gnt", 64'(bus.p_gnt), 64'(0));
      chk("rst.ack", 64'(bus.p_ack), 64'(0));
      rst = 1'b0;
      bus.p_req = '0;
      saw_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (bus.p_ack != '0 || bus.mem_req) saw_ack = 1'b1;
      end
      chk("rst.quiet", 64'(saw_ack), 64'(0));
      run_vec(vecs[0], "rst.after");
    end

    // Requester drops p_req in ADDR: transfer still completes, no regrant.
    begin
      logic busy;
      set_port(0, 1'b0, 32'h404, 4'h1, 32'h0);
      bus.p_req[0] = 1'b1;
      tick();
      bus.p_req[0] = 1'b0;
      tick();
      bus.mem_rdata = 32'h0BAD_F00D;
      tick();
      bus.mem_rdata = '0;
      chk("drop.ack", 64'(bus.p_ack), 64'(2'b01));
      chk("drop.rdata", 64'(bus.p_rdata), 64'(32'h0BAD_F00D));
      busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
        tick();
        if (bus.p_gnt != '0 || bus.mem_req) busy = 1'b1;
      end
      chk("drop.no_regrant", 64'(busy), 64'(0));
    end

    // Randomized traffic against the transaction-level model.
    do_reset();
    pend = '0;
`ifdef MEM_ARB_RR_EN
    rr_next = 0;
`endif
    for (int t = 0; t < 300; t++) begin
      int unsigned win;
      logic [31:0] r;
      logic        e;
      for (int unsigned p = 0; p < NP; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          pend[p]   = 1'b1;
          m_we[p]   = 1'($urandom_range(0, 1));
          m_addr[p] = $urandom;
          m_be[p]   = 4'($urandom_range(0, 15));
          m_wd[p]   = $urandom;
          set_port(p, m_we[p], m_addr[p], m_be[p], m_wd[p]);
          bus.p_req[p] = 1'b1;
        end
      end
      if (pend == '0) begin
        tick();
        continue;
      end
      win = model_pick(pend);
`ifdef MEM_ARB_RR_EN
      rr_next = (win + 1) % NP;
`endif
      tick();
      chk("rnd.gnt", 64'(bus.p_gnt), 64'(onehot(win)));
      chk("rnd.mem_addr", 64'(bus.mem_addr), 64'({m_addr[win][31:2], 2'b00}));
      chk("rnd.mem_we", 64'(bus.mem_we), 64'(m_we[win]));
      chk("rnd.mem_wdata", 64'(bus.mem_wdata), 64'(m_wd[win]));
      set_port(win, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), $urandom);
      tick();
      r = $urandom;
      e = 1'($urandom_range(0, 1));
      bus.mem_rdata = r;
      bus.mem_err   = e;
      chk("rnd.byteen", 64'(bus.mem_byteen), 64'(m_be[win]));
      tick();
      bus.mem_rdata = '0;
      bus.mem_err   = 1'b0;
      chk("rnd.ack", 64'(bus.p_ack), 64'(onehot(win)));
      chk("rnd.rdata", 64'(bus.p_rdata), 64'(m_we[win] ? 32'h0 : r));
      chk("rnd.err", 64'(bus.p_err), 64'(e));
      bus.p_req[win] = 1'b0;
      pend[win] = 1'b0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
